// File: rtl/memory_request_unit.sv
// Arbitrates core fetch/data requests onto one RAM port; data wins, ready pulses 2+ cycles after acceptance, core holds requests until ready.
// Optional REQUEST_TIMEOUT_EN bounds each RAM wait to TIMEOUT_CYCLES, returning ERR_WORD on reads and flagging err.
module memory_request_unit #(
   parameter int          TIMEOUT_CYCLES = 255,
   parameter logic [31:0] ERR_WORD       = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        nRST,
   input  logic        i_req,
   input  logic [31:0] imemaddr,
   input  logic        d_ren,
   input  logic        d_wen,
   input  logic [31:0] dmmaddr,
   input  logic [31:0] dmmstore,
   input  logic [31:0] ramload,
   input  logic        ram_ready,
   output logic [31:0] ramaddr,
   output logic [31:0] ramstore,
   output logic        ramREN,
   output logic        ramWEN,
   output logic [31:0] imemload,
   output logic [31:0] dmemload,
   output logic        i_ready,
   output logic        d_ready,
   output logic        err
);

   typedef enum logic [1:0] {IDLE, IFETCH, DATA, DONE} state_t;

   state_t      state_q, state_d;
   logic [31:0] ramaddr_q, ramaddr_d;
   logic [31:0] ramstore_q, ramstore_d;
   logic        ramren_q, ramren_d;
   logic        ramwen_q, ramwen_d;
   logic [31:0] imemload_q, imemload_d;
   logic [31:0] dmemload_q, dmemload_d;
   logic        i_ready_q, i_ready_d;
   logic        d_ready_q, d_ready_d;

   if (TIMEOUT_CYCLES < 1) begin : g_tmo_chk
      $error("TIMEOUT_CYCLES must be at least 1");
   end

`ifdef REQUEST_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          err_q, err_d;
`endif

   always_comb begin
      state_d    = state_q;
      ramaddr_d  = ramaddr_q;
      ramstore_d = ramstore_q;
      ramren_d   = ramren_q;
      ramwen_d   = ramwen_q;
      imemload_d = imemload_q;
      dmemload_d = dmemload_q;
      i_ready_d  = 1'b0;
      d_ready_d  = 1'b0;
`ifdef REQUEST_TIMEOUT_EN
      cnt_d      = cnt_q;
      err_d      = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            // A simultaneous read+write is carried out as a write only.
            if (d_ren || d_wen) begin
               state_d    = DATA;
               ramaddr_d  = dmmaddr;
               ramstore_d = d_wen ? dmmstore : 32'h0;
               ramren_d   = ~d_wen;
               ramwen_d   = d_wen;
`ifdef REQUEST_TIMEOUT_EN
               cnt_d      = '0;
`endif
            end else if (i_req) begin
               state_d    = IFETCH;
               ramaddr_d  = imemaddr;
               ramstore_d = 32'h0;
               ramren_d   = 1'b1;
               ramwen_d   = 1'b0;
`ifdef REQUEST_TIMEOUT_EN
               cnt_d      = '0;
`endif
            end
         end
         IFETCH, DATA: begin
            if (ram_ready) begin
               state_d   = DONE;
               ramren_d  = 1'b0;
               ramwen_d  = 1'b0;
               i_ready_d = (state_q == IFETCH);
               d_ready_d = (state_q == DATA);
               if (state_q == IFETCH) begin
                  imemload_d = ramload;
               end else if (!ramwen_q) begin
                  dmemload_d = ramload;
               end
            end
`ifdef REQUEST_TIMEOUT_EN
            // ram_ready on the final wait edge still wins over the timeout.
            else if (cnt_q == CNT_LAST) begin
               state_d   = DONE;
               ramren_d  = 1'b0;
               ramwen_d  = 1'b0;
               i_ready_d = (state_q == IFETCH);
               d_ready_d = (state_q == DATA);
               err_d     = 1'b1;
               if (state_q == IFETCH) begin
                  imemload_d = ERR_WORD;
               end else if (!ramwen_q) begin
                  dmemload_d = ERR_WORD;
               end
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge nRST) begin
      if (!nRST) begin
         state_q    <= IDLE;
         ramaddr_q  <= 32'h0;
         ramstore_q <= 32'h0;
         ramren_q   <= 1'b0;
         ramwen_q   <= 1'b0;
         imemload_q <= 32'h0;
         dmemload_q <= 32'h0;
         i_ready_q  <= 1'b0;
         d_ready_q  <= 1'b0;
`ifdef REQUEST_TIMEOUT_EN
         cnt_q      <= '0;
         err_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         ramaddr_q  <= ramaddr_d;
         ramstore_q <= ramstore_d;
         ramren_q   <= ramren_d;
         ramwen_q   <= ramwen_d;
         imemload_q <= imemload_d;
         dmemload_q <= dmemload_d;
         i_ready_q  <= i_ready_d;
         d_ready_q  <= d_ready_d;
`ifdef REQUEST_TIMEOUT_EN
         cnt_q      <= cnt_d;
         err_q      <= err_d;
`endif
      end
   end

   assign ramaddr  = ramaddr_q;
   assign ramstore = ramstore_q;
   assign ramREN   = ramren_q;
   assign ramWEN   = ramwen_q;
   assign imemload = imemload_q;
   assign dmemload = dmemload_q;
   assign i_ready  = i_ready_q;
   assign d_ready  = d_ready_q;
`ifdef REQUEST_TIMEOUT_EN
   assign err      = err_q;
`else
   assign err      = 1'b0;
`endif

endmodule
